// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash access engines: opcodes, FSM states, address width.
package spi_flash_pkg;

   localparam int         ADDR_W       = 24;
   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;

   typedef enum logic [2:0] {
      IDLE,
      CSS,
      CMD,
      ADDR,
      DUMMY,
      DATA,
      CSH,
      DONE
   } state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 clock generator: each bit is CLK_DIV low cycles then CLK_DIV high cycles while en is held.
module spi_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic sclk,
   input  logic rst,
   input  logic en,
   output logic sck,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * CLK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_sck;

   always_comb begin
      w_cnt_next = '0;
      if (en && (r_cnt != CNT_LAST)) begin
         w_cnt_next = r_cnt + 1'b1;
      end
   end

   // r_sck tracks the phase of the counter it is loaded alongside, so it is a clean flop output
   always_ff @(posedge sclk) begin
      if (rst) begin
         r_cnt <= '0;
         r_sck <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         r_sck <= (w_cnt_next >= CNT_HALF);
      end
   end

   assign sck  = r_sck;
   assign rise = en && (r_cnt == CNT_HALF);
   // last high cycle of a bit; sck drops at the next edge
   assign fall = en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/spi_byte_read.sv
// SPI flash read engine (mode 0): READ + 24-bit address, then rd_len bytes shifted in MSB first.
// Define FAST_READ_EN to use opcode 0x0B with 8 dummy clocks ahead of the data phase.
module spi_byte_read
   import spi_flash_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int CS_SETUP = 2,
   parameter int LEN_W    = 8
) (
   input  logic              sclk,
   input  logic              rst,
   input  logic              rd_start,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [LEN_W-1:0]  rd_len,
   output logic              busy,
   output logic [7:0]        rd_data,
   output logic              rd_flag,
   output logic              rd_done,
   output logic              cs_n,
   output logic              sck,
   output logic              sdi,
   input  logic              sdo
);

`ifdef FAST_READ_EN
   localparam logic [7:0] OPCODE = OP_FAST_READ;
`else
   localparam logic [7:0] OPCODE = OP_READ;
`endif

   localparam int WAIT_W = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CS_SETUP - 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic [4:0]         r_bit_cnt;
   logic [LEN_W-1:0]   r_byte_cnt;
   logic [31:0]        r_shift;
   logic [6:0]         r_rx;
   logic [7:0]         r_rd_data;
   logic               r_rd_flag;

   logic               w_accept;
   logic               w_shift_en;
   logic               w_rise;
   logic               w_fall;
   logic               w_byte_end;

   assign w_accept   = (r_state == IDLE) && rd_start && (rd_len != '0);
   assign w_shift_en = (r_state == CMD) || (r_state == ADDR) ||
                       (r_state == DUMMY) || (r_state == DATA);
   assign w_byte_end = w_fall && (r_bit_cnt == 5'd7);

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .sclk (sclk),
      .rst  (rst),
      .en   (w_shift_en),
      .sck  (sck),
      .rise (w_rise),
      .fall (w_fall)
   );

   always_ff @(posedge sclk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:  if (w_accept) w_state_next = CSS;
         CSS:   if (r_wait_cnt == WAIT_LAST) w_state_next = CMD;
         CMD:   if (w_byte_end) w_state_next = ADDR;
`ifdef FAST_READ_EN
         ADDR:  if (w_fall && (r_bit_cnt == 5'd23)) w_state_next = DUMMY;
`else
         ADDR:  if (w_fall && (r_bit_cnt == 5'd23)) w_state_next = DATA;
`endif
         DUMMY: if (w_byte_end) w_state_next = DATA;
         DATA:  if (w_byte_end && (r_byte_cnt == LEN_W'(1))) w_state_next = CSH;
         CSH:   if (r_wait_cnt == WAIT_LAST) w_state_next = DONE;
         DONE:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         r_wait_cnt <= '0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_shift    <= '0;
         r_rx       <= '0;
         r_rd_data  <= '0;
         r_rd_flag  <= 1'b0;
      end else begin
         r_rd_flag <= 1'b0;

         if (w_state_next != r_state) begin
            r_wait_cnt <= '0;
         end else if ((r_state == CSS) || (r_state == CSH)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end

         // bit counter restarts per phase, and per byte inside DATA
         if (w_state_next != r_state) begin
            r_bit_cnt <= '0;
         end else if (w_fall) begin
            if ((r_state == DATA) && (r_bit_cnt == 5'd7)) begin
               r_bit_cnt <= '0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 5'd1;
            end
         end

         if (w_accept) begin
            r_byte_cnt <= rd_len;
         end else if ((r_state == DATA) && w_byte_end) begin
            r_byte_cnt <= r_byte_cnt - 1'b1;
         end

         // Loaded at accept: the opcode MSB is 0, so sdi stays low through CSS.
         // Zeros shift in behind the address, which keeps sdi low for DUMMY and DATA.
         if (w_accept) begin
            r_shift <= {OPCODE, rd_addr};
         end else if (w_fall) begin
            r_shift <= {r_shift[30:0], 1'b0};
         end

         if ((r_state == DATA) && w_rise) begin
            r_rx <= {r_rx[5:0], sdo};
            if (r_bit_cnt == 5'd7) begin
               r_rd_data <= {r_rx, sdo};
               r_rd_flag <= 1'b1;
            end
         end
      end
   end

   assign busy    = (r_state != IDLE);
   assign rd_done = (r_state == DONE);
   assign cs_n    = (r_state == IDLE) || (r_state == DONE);
   assign sdi     = r_shift[31];
   assign rd_data = r_rd_data;
   assign rd_flag = r_rd_flag;

endmodule

// File: tb/tb_spi_byte_read.sv
// Randomized scoreboard bench for spi_byte_read with a behavioural SPI flash model on the pins.
module tb_spi_byte_read;

   localparam int CLK_DIV  = 2;
   localparam int CS_SETUP = 2;
   localparam int LEN_W    = 8;
`ifdef FAST_READ_EN
   localparam logic [7:0] OPC = 8'h0B;
   localparam int         HDR = 40;
`else
   localparam logic [7:0] OPC = 8'h03;
   localparam int         HDR = 32;
`endif

   typedef struct {
      logic [23:0] addr;
      int          len;
   } txn_t;

   logic             sclk = 1'b0;
   logic             rst;
   logic             rd_start;
   logic [23:0]      rd_addr;
   logic [LEN_W-1:0] rd_len;
   logic             busy;
   logic [7:0]       rd_data;
   logic             rd_flag;
   logic             rd_done;
   logic             cs_n;
   logic             sck;
   logic             sdi;
   logic             fl_sdo = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mem [int unsigned];
   logic [7:0] exp_q [$];
   txn_t       txn_q [$];

   spi_byte_read #(
      .CLK_DIV  (CLK_DIV),
      .CS_SETUP (CS_SETUP),
      .LEN_W    (LEN_W)
   ) dut (
      .sclk     (sclk),
      .rst      (rst),
      .rd_start (rd_start),
      .rd_addr  (rd_addr),
      .rd_len   (rd_len),
      .busy     (busy),
      .rd_data  (rd_data),
      .rd_flag  (rd_flag),
      .rd_done  (rd_done),
      .cs_n     (cs_n),
      .sck      (sck),
      .sdi      (sdi),
      .sdo      (fl_sdo)
   );

   always #5 sclk = ~sclk;

   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Flash model plus output monitor, all sampled on the falling sclk edge.
   logic        sck_prev = 1'b0;
   logic        cs_prev  = 1'b1;
   int          fl_bits, fl_ones, k;
   logic [31:0] fl_hdr;
   logic [23:0] fl_a;
   logic [7:0]  fl_b;
   int          last_bits, last_ones;
   logic [31:0] last_hdr;
   int          flags_in_txn = 0;
   int          cyc = 0;
   int          last_flag_cyc = 0;
   logic [7:0]  exp_b;
   txn_t        mt;

   always @(negedge sclk) begin
      cyc++;
      if (!cs_n && cs_prev) begin
         fl_bits = 0;
         fl_ones = 0;
         fl_hdr  = '0;
         flags_in_txn = 0;
      end
      if (!cs_n) begin
         if (sck && !sck_prev) begin
            if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], sdi};
            else if (sdi) fl_ones++;
            fl_bits++;
         end else if (!sck && sck_prev && fl_bits >= HDR) begin
            k      = fl_bits - HDR;
            fl_a   = fl_hdr[23:0] + 24'(k / 8);
            fl_b   = flash_byte(fl_a);
            fl_sdo = fl_b[7 - (k % 8)];
         end
      end
      if (cs_n && !cs_prev) begin
         last_hdr  = fl_hdr;
         last_bits = fl_bits;
         last_ones = fl_ones;
      end

      if (rd_flag) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_flag: got rd_data %0h expected no flag", rd_data);
         end else begin
            exp_b = exp_q.pop_front();
            check("rd_data", rd_data, exp_b);
            if (flags_in_txn > 0) check("flag_gap", cyc - last_flag_cyc, 16 * CLK_DIV);
         end
         last_flag_cyc = cyc;
         flags_in_txn++;
      end

      if (rd_done) begin
         if (txn_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got rd_done 1 expected 0");
         end else begin
            mt = txn_q.pop_front();
            check("sdi_header", last_hdr, {OPC, mt.addr});
            check("sck_rises", last_bits, HDR + 8 * mt.len);
            check("flag_count", flags_in_txn, mt.len);
            check("sdi_low_in_data", last_ones, 0);
            check("cs_n_at_done", cs_n, 1);
         end
      end

      sck_prev = sck;
      cs_prev  = cs_n;
   end

   task automatic pulse_reset();
      @(negedge sclk);
      rst = 1'b1;
      @(negedge sclk);
      rst = 1'b0;
   endtask

   task automatic do_read(input logic [23:0] addr, input int len, input bit mid);
      txn_t t;
      bit   done;
      int   budget;
      t.addr = addr;
      t.len  = len;
      txn_q.push_back(t);
      for (int i = 0; i < len; i++) exp_q.push_back(flash_byte(addr + 24'(i)));
      @(negedge sclk);
      rd_start = 1'b1;
      rd_addr  = addr;
      rd_len   = LEN_W'(len);
      @(negedge sclk);
      rd_start = 1'b0;
      rd_addr  = 24'($urandom);
      check("busy_after_accept", busy, 1);
      check("cs_n_after_accept", cs_n, 0);
      budget = (HDR + 8 * len) * 2 * CLK_DIV + 2 * CS_SETUP + 20;
      done   = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         if (mid && c == 30) begin
            rd_start = 1'b1;
            rd_addr  = addr ^ 24'h5A5A5A;
            rd_len   = LEN_W'(3);
         end else begin
            rd_start = 1'b0;
         end
         @(negedge sclk);
         if (rd_done) done = 1'b1;
      end
      rd_start = 1'b0;
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: got no rd_done expected rd_done within %0d cycles", budget);
         pulse_reset();
         txn_q.delete();
         exp_q.delete();
      end
      repeat (3) @(negedge sclk);
      check("busy_idle", busy, 0);
      $display("read addr=%06h len=%0d mid_start=%0d done=%0d", addr, len, mid, done);
   endtask

   initial begin
      mem[32'h123456] = 8'hA5;
      mem[32'h000100] = 8'h11;
      mem[32'h000101] = 8'h22;
      mem[32'h000102] = 8'h33;
      mem[32'h000103] = 8'h44;
      rst      = 1'b1;
      rd_start = 1'b0;
      rd_addr  = '0;
      rd_len   = '0;
      repeat (3) @(negedge sclk);
      check("rst_cs_n", cs_n, 1);
      check("rst_sck", sck, 0);
      check("rst_sdi", sdi, 0);
      check("rst_busy", busy, 0);
      check("rst_flag", rd_flag, 0);
      check("rst_done", rd_done, 0);
      check("rst_data", rd_data, 0);
      rst = 1'b0;
      @(negedge sclk);

      do_read(24'h123456, 1, 1'b0);
      check("rd_data_hold", rd_data, 8'hA5);
      do_read(24'h000100, 4, 1'b0);
      do_read(24'h000100, 4, 1'b1);

      // zero-length request must leave the pins idle
      @(negedge sclk);
      rd_start = 1'b1;
      rd_addr  = 24'h333333;
      rd_len   = '0;
      @(negedge sclk);
      rd_start = 1'b0;
      check("len0_busy", busy, 0);
      check("len0_cs_n", cs_n, 1);
      repeat (10) @(negedge sclk);
      check("len0_busy_later", busy, 0);
      check("len0_sck", sck, 0);
      $display("read addr=333333 len=0 ignored");

      // abort in the address phase
      @(negedge sclk);
      rd_start = 1'b1;
      rd_addr  = 24'hABCDEF;
      rd_len   = LEN_W'(2);
      @(negedge sclk);
      rd_start = 1'b0;
      repeat (CS_SETUP + 18 * 2 * CLK_DIV) @(negedge sclk);
      check("pre_abort_cs_n", cs_n, 0);
      rst = 1'b1;
      @(negedge sclk);
      rst = 1'b0;
      check("abort_cs_n", cs_n, 1);
      check("abort_sck", sck, 0);
      check("abort_busy", busy, 0);
      check("abort_sdi", sdi, 0);
      $display("read addr=abcdef len=2 aborted by reset");
      repeat (4) @(negedge sclk);
      do_read(24'h123456, 1, 1'b0);

      for (int i = 0; i < 6; i++) begin
         do_read(24'($urandom), int'($urandom_range(1, 5)), bit'($urandom_range(0, 1)));
      end
      do_read(24'hFFFFFE, 3, 1'b0);
      do_read(24'($urandom), 255, 1'b0);

      check("exp_q_empty", exp_q.size(), 0);
      check("txn_q_empty", txn_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spi_byte_read.md
Name: spi_byte_read

Overview:
- SPI flash read engine (M25P16-class, SPI mode 0). It is the read-side counterpart of the byte-write path and drives the same flash pins.
- Takes a start pulse, a 24-bit address and a byte count. Issues READ (0x03) plus the address, then shifts in the requested bytes from the flash SDO line.
- Presents each received byte with a one-cycle flag for downstream UART or loader logic.

Parameters:
- CLK_DIV, 2: sclk cycles per SCK half-period, minimum 1.
- CS_SETUP, 2: sclk cycles from cs_n falling to the first SCK edge activity, and from the last SCK fall to cs_n rising.
- LEN_W, 8: width of the byte-count input.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- rd_start  in  1  one-cycle request; sampled only when busy=0.
- rd_addr  in  24  flash start address; captured with rd_start.
- rd_len  in  LEN_W  bytes to read; captured with rd_start.
- busy  out  1  high from the cycle after an accepted rd_start through the rd_done cycle.
- rd_data  out  8  last received byte, MSB first on the wire; holds its value between flags.
- rd_flag  out  1  one-cycle pulse when rd_data is updated.
- rd_done  out  1  one-cycle pulse in the cycle cs_n returns high.
- cs_n  out  1  flash chip select, active-low.
- sck  out  1  SPI clock; idles low.
- sdi  out  1  MOSI to the flash.
- sdo  in  1  MISO from the flash.

Behaviour:
- Reset values: cs_n=1, sck=0, sdi=0, busy=0, rd_flag=0, rd_done=0, rd_data=0x00.
- Reset asserted mid-transaction aborts it. Next cycle all outputs are at reset values; no rd_done is issued.
- Request acceptance:
  - rd_start with busy=0 and rd_len!=0 is accepted.
  - rd_start with rd_len=0 is ignored; no pin activity.
  - rd_start while busy=1 is ignored.
- State machine:
  - IDLE -> CSS on accepted start; cs_n drops the next cycle.
  - CSS waits CS_SETUP cycles -> CMD.
  - CMD shifts 8 bits -> ADDR.
  - ADDR shifts 24 bits -> DATA.
  - DATA shifts 8*len bits -> CSH.
  - CSH keeps cs_n low for CS_SETUP cycles -> DONE.
  - DONE raises cs_n and pulses rd_done for one cycle -> IDLE.
- Bit timing (mode 0):
  - Each bit is 2*CLK_DIV sclk cycles: sck low for CLK_DIV, then high for CLK_DIV.
  - sdi is updated at the start of the low phase.
  - sdo is sampled in the cycle sck goes high.
- sdi content: sdi carries opcode then address, MSB first, and is held 0 during DATA.
- Byte delivery:
  - After each 8th sampled data bit, rd_data updates and rd_flag pulses in the next sclk cycle.
  - Consecutive flags are 16*CLK_DIV cycles apart.
- Total SCK rising edges per transaction = 32 + 8*rd_len.
- Byte and bit counters are sized for the full LEN_W range: len = 2^LEN_W-1 must complete without wrap.
- Address wrap at the top of flash is the flash's behaviour; this block does not alter the address.

Optional Feature:
- Macro FAST_READ_EN.
- Defined: opcode 0x0B, plus 8 dummy SCK cycles (sdi=0, sdo ignored) in a DUMMY state between ADDR and DATA. SCK edges = 40 + 8*rd_len.
- Undefined: opcode 0x03, no DUMMY state.

Decomposition:
- Package spi_flash_pkg holds:
  - opcodes OP_READ=0x03 and OP_FAST_READ=0x0B;
  - state enum (IDLE, CSS, CMD, ADDR, DUMMY, DATA, CSH, DONE);
  - ADDR_W=24.
- One natural sub-module, spi_sck_gen: CLK_DIV counter producing sck plus single-cycle rise/fall strobes, enabled by the FSM.

Test Plan:
- Single byte, rd_addr=0x123456, rd_len=1; flash model returns 0xA5 -> sdi stream 0x03,0x12,0x34,0x56; exactly 40 SCK rises; one rd_flag with rd_data=0xA5; rd_done once; cs_n high after.
- Burst, rd_addr=0x000100, rd_len=4; model returns 0x11,0x22,0x33,0x44 -> four rd_flags in order, spaced 16*CLK_DIV cycles; 64 SCK rises.
- rd_start pulsed again mid-transfer with different address -> ignored; sdi stream and data unchanged; single rd_done.
- rd_len=0 start -> busy stays 0, cs_n stays 1, no rd_flag/rd_done.
- rst asserted during ADDR phase -> next cycle cs_n=1, sck=0, busy=0; new request afterwards completes correctly.
- With FAST_READ_EN, rd_len=1 -> opcode 0x0B, 8 dummy clocks, 48 SCK rises, byte 0xA5 captured.
